dwc_retry_ctrl: RTL

Sequencing controller for the duplicate-with-compare (DWC) comparator. It accepts an operand pair from the duplicated producers and drives the comparator's load/arm handshake (data_set 1/2/3). It collects the match result, requests re-execution on mismatch up to a retry limit, and watchdogs the comparator. It then raises one interrupt with final status to the MicroBlaze and waits for the host acknowledge.

---
 rtl/dwc_retry_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/dwc_retry_ctrl.sv
// DWC comparator sequencer: load/arm handshake, retry on mismatch,
// watchdog on comparator done, single interrupt with final status.
module dwc_retry_ctrl #(
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              req_ready,
    output logic              retry_req,
    output logic [DATA_W-1:0] cmp_data_a,
    output logic [DATA_W-1:0] cmp_data_b,
    output logic [31:0]       cmp_data_set,
    output logic [31:0]       cmp_ack,
    input  logic [31:0]       cmp_done,
    input  logic [31:0]       cmp_match,
    output logic              irq,
    input  logic              host_ack,
    output logic              st_match,
    output logic              st_fault,
    output logic              st_timeout,
    output logic [CNT_W-1:0]  retry_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_ARM,
        S_WAIT,
        S_ACK,
        S_RWAIT,
        S_REPORT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_live;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [WD_W-1:0]   r_wdog;
    logic              r_match;
    logic              r_st_match;
    logic              r_st_fault;
    logic              r_st_to;
    logic [CNT_W-1:0]  r_retry_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_retry_req;

    logic w_done;
    logic w_accept;
    logic w_to;
    logic w_retry;
    logic w_fault;
    logic w_set_match;
    logic w_clear;

    assign w_done = |cmp_done;

    // Next-state and event decode.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_to        = 1'b0;
        w_retry     = 1'b0;
        w_fault     = 1'b0;
        w_set_match = 1'b0;
        w_clear     = 1'b0;
        unique case (r_state)
            S_IDLE, S_RWAIT: begin
                if (req_valid && r_live) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD_A;
                end
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_LOAD_B: w_next = S_ARM;
            S_ARM:    w_next = S_WAIT;
            S_WAIT: begin
                if (w_done) begin
                    w_next = S_ACK;
                end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                    w_to   = 1'b1;
                    w_next = S_REPORT;
                end
            end
            S_ACK: begin
                if (!w_done) begin
                    if (r_match) begin
                        w_set_match = 1'b1;
                        w_next      = S_REPORT;
                    end else if (r_retry_cnt < CNT_W'(MAX_RETRY)) begin
                        w_retry = 1'b1;
                        w_next  = S_RWAIT;
                    end else begin
                        w_fault = 1'b1;
                        w_next  = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (host_ack) begin
                    w_clear = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register; r_live keeps req_ready low while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    // Operand holding registers, driven straight to the comparator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_accept) begin
            r_a <= req_a;
            r_b <= req_b;
        end
    end

    // Watchdog and match latch for the comparator wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog  <= '0;
            r_match <= 1'b0;
        end else if (r_state == S_ARM) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT) begin
            r_wdog <= r_wdog + 1'b1;
            if (w_done) begin
                r_match <= |cmp_match;
            end
        end
    end

    // Final status bits, held until the host acknowledges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_st_match <= 1'b0;
            r_st_fault <= 1'b0;
            r_st_to    <= 1'b0;
        end else if (w_clear) begin
            r_st_match <= 1'b0;
            r_st_fault <= 1'b0;
            r_st_to    <= 1'b0;
        end else begin
            if (w_set_match) r_st_match <= 1'b1;
            if (w_fault)     r_st_fault <= 1'b1;
            if (w_to)        r_st_to    <= 1'b1;
        end
    end

    // Retry counter, lifetime error counter and retry pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retry_cnt <= '0;
            r_err_cnt   <= '0;
            r_retry_req <= 1'b0;
        end else begin
            r_retry_req <= w_retry;
            if (w_clear) begin
                r_retry_cnt <= '0;
            end else if (w_retry) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end
            if ((w_retry || w_fault) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    // Comparator handshake decoded from state.
    always_comb begin
        cmp_data_set = 32'd0;
        unique case (r_state)
            S_LOAD_A: cmp_data_set = 32'd1;
            S_LOAD_B: cmp_data_set = 32'd2;
            S_ARM:    cmp_data_set = 32'd3;
            S_WAIT:   cmp_data_set = 32'd3;
            default:  cmp_data_set = 32'd0;
        endcase
    end

    assign cmp_ack    = {31'd0, r_state == S_ACK};
    assign cmp_data_a = r_a;
    assign cmp_data_b = r_b;
    assign req_ready  = r_live &&
                        ((r_state == S_IDLE) || (r_state == S_RWAIT));
    assign irq        = (r_state == S_REPORT);
    assign retry_req  = r_retry_req;
    assign st_match   = r_st_match;
    assign st_fault   = r_st_fault;
    assign st_timeout = r_st_to;
    assign retry_cnt  = r_retry_cnt;
    assign err_cnt    = r_err_cnt;

endmodule
